// File: rtl/raster_coord_tagger_if.sv
// Pixel stream bundle between a raw pixel source and raster_coord_tagger:
// raw pixels and error clear in, tagged pixels and frame status out.
interface raster_coord_tagger_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_i;
    logic                  valid_i;
    logic                  sof_i;
    logic                  err_clear_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic [15:0]           col_o;
    logic [15:0]           row_o;
    logic                  valid_o;
    logic                  frame_done_o;
    logic [15:0]           frame_count_o;
    logic                  short_frame_err_o;
    logic                  overrun_err_o;

    modport master (
        output data_i, valid_i, sof_i, err_clear_i,
        input  data_o, col_o, row_o, valid_o, frame_done_o, frame_count_o,
               short_frame_err_o, overrun_err_o
    );

    modport slave (
        input  data_i, valid_i, sof_i, err_clear_i,
        output data_o, col_o, row_o, valid_o, frame_done_o, frame_count_o,
               short_frame_err_o, overrun_err_o
    );
endinterface

// File: rtl/raster_coord_tagger.sv
// Tags each accepted pixel of a push-only stream with its raster column/row,
// flags framing errors and counts completed frames.
module raster_coord_tagger #(
    parameter int DATA_WIDTH   = 0,
    parameter int IMAGE_WIDTH  = 0,
    parameter int IMAGE_HEIGHT = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    raster_coord_tagger_if.slave  bus
);
    typedef enum logic [0:0] {WAIT_SOF, ACTIVE} state_t;

    localparam logic [15:0] COL_LAST = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] ROW_LAST = 16'(IMAGE_HEIGHT - 1);

    state_t                state_q, state_d;
    logic [15:0]           col_q, row_q, col_d, row_d;
    logic [15:0]           pos_col, pos_row;
    logic                  emit, done, set_short, set_overrun;

    logic [DATA_WIDTH-1:0] data_q;
    logic [15:0]           col_out, row_out, count_q;
    logic                  valid_q, done_q, short_q, overrun_q;

    // A sof pixel always lands at (0,0); the following position is derived from
    // whatever position was just emitted, so restart and normal flow share one path.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        pos_col     = col_q;
        pos_row     = row_q;
        emit        = 1'b0;
        done        = 1'b0;
        set_short   = 1'b0;
        set_overrun = 1'b0;

        if (bus.valid_i) begin
            if (bus.sof_i) begin
                emit      = 1'b1;
                pos_col   = 16'd0;
                pos_row   = 16'd0;
                set_short = (state_q == ACTIVE);
            end else if (state_q == ACTIVE) begin
                emit = 1'b1;
            end else begin
                set_overrun = 1'b1;
            end
        end

        if (emit) begin
            if (pos_col == COL_LAST) begin
                col_d = 16'd0;
                if (pos_row == ROW_LAST) begin
                    done    = 1'b1;
                    row_d   = 16'd0;
                    state_d = WAIT_SOF;
                end else begin
                    row_d   = pos_row + 16'd1;
                    state_d = ACTIVE;
                end
            end else begin
                col_d   = pos_col + 16'd1;
                row_d   = pos_row;
                state_d = ACTIVE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= WAIT_SOF;
            col_q   <= 16'd0;
            row_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Sticky flags: a new error in the clearing cycle takes priority over the clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q    <= '0;
            col_out   <= 16'd0;
            row_out   <= 16'd0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= 16'd0;
            short_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q <= emit;
            done_q  <= done;
            if (emit) begin
                data_q  <= bus.data_i;
                col_out <= pos_col;
                row_out <= pos_row;
            end
            if (done) begin
                count_q <= count_q + 16'd1;
            end
            short_q   <= set_short   | (short_q   & ~bus.err_clear_i);
            overrun_q <= set_overrun | (overrun_q & ~bus.err_clear_i);
        end
    end

    assign bus.data_o            = data_q;
    assign bus.col_o             = col_out;
    assign bus.row_o             = row_out;
    assign bus.valid_o           = valid_q;
    assign bus.frame_done_o      = done_q;
    assign bus.frame_count_o     = count_q;
    assign bus.short_frame_err_o = short_q;
    assign bus.overrun_err_o     = overrun_q;
endmodule

// File: tb/tb_raster_coord_tagger.sv
// Directed bench for raster_coord_tagger: a 4x3 instance for framing behaviour
// and a 1x1 instance for single-pixel frames and frame counter wrap.
module tb_raster_coord_tagger;
    logic clk_i = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   checks = 0;
    int   errors = 0;

    raster_coord_tagger_if #(.DATA_WIDTH(8)) bus_a ();
    raster_coord_tagger_if #(.DATA_WIDTH(8)) bus_b ();

    raster_coord_tagger #(.DATA_WIDTH(8), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(3)) dut_a (
        .clk_i (clk_i),
        .rst_i (rst_a),
        .bus   (bus_a)
    );

    raster_coord_tagger #(.DATA_WIDTH(8), .IMAGE_WIDTH(1), .IMAGE_HEIGHT(1)) dut_b (
        .clk_i (clk_i),
        .rst_i (rst_b),
        .bus   (bus_b)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkPixelA(input string tag, input bit exp_valid, input int exp_col,
                               input int exp_row, input int exp_data, input bit exp_done);
        checkOutput({tag, "_valid"}, 32'(bus_a.valid_o), 32'(exp_valid));
        checkOutput({tag, "_done"}, 32'(bus_a.frame_done_o), 32'(exp_done));
        if (exp_valid) begin
            checkOutput({tag, "_col"}, 32'(bus_a.col_o), 32'(exp_col));
            checkOutput({tag, "_row"}, 32'(bus_a.row_o), 32'(exp_row));
            checkOutput({tag, "_data"}, 32'(bus_a.data_o), 32'(exp_data));
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic applyStimulus(input bit v, input bit s, input int d, input bit c);
        bus_a.valid_i     = v;
        bus_a.sof_i       = s;
        bus_a.data_i      = 8'(d);
        bus_a.err_clear_i = c;
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulusB(input bit v, input bit s, input int d);
        bus_b.valid_i     = v;
        bus_b.sof_i       = s;
        bus_b.data_i      = 8'(d);
        bus_b.err_clear_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic sendFrameA(input string tag, input int base, input bit bubbles,
                              input int exp_count);
        for (int i = 0; i < 12; i++) begin
            if (bubbles) begin
                int nb;
                nb = int'($urandom_range(0, 3));
                for (int b = 0; b < nb; b++) begin
                    applyStimulus(0, 0, 8'hEE, 0);
                    checkOutput({tag, "_bubble_valid"}, 32'(bus_a.valid_o), 32'd0);
                    if (i > 0) checkOutput({tag, "_bubble_col_hold"}, 32'(bus_a.col_o), 32'((i - 1) % 4));
                end
            end
            applyStimulus(1, i == 0, base + i, 0);
            checkPixelA($sformatf("%s_px%0d", tag, i), 1, i % 4, i / 4, base + i, i == 11);
        end
        checkOutput({tag, "_count"}, 32'(bus_a.frame_count_o), 32'(exp_count));
        checkOutput({tag, "_short"}, 32'(bus_a.short_frame_err_o), 32'd0);
        checkOutput({tag, "_overrun"}, 32'(bus_a.overrun_err_o), 32'd0);
    endtask

    initial begin
        bus_a.valid_i = 0; bus_a.sof_i = 0; bus_a.data_i = 0; bus_a.err_clear_i = 0;
        bus_b.valid_i = 0; bus_b.sof_i = 0; bus_b.data_i = 0; bus_b.err_clear_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        checkPixelA("reset", 0, 0, 0, 0, 0);
        checkOutput("reset_count", 32'(bus_a.frame_count_o), 32'd0);
        checkOutput("reset_data", 32'(bus_a.data_o), 32'd0);
        checkOutput("reset_col", 32'(bus_a.col_o), 32'd0);
        checkOutput("reset_errs", 32'({bus_a.short_frame_err_o, bus_a.overrun_err_o}), 32'd0);
        rst_a = 0;
        rst_b = 0;

        // Back-to-back frame with pixels 1..12, one-cycle latency checked per pixel.
        sendFrameA("t1", 1, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkPixelA("t1_idle", 0, 0, 0, 0, 0);

        // Same frame with random bubbles, then a second frame immediately after.
        sendFrameA("t2a", 1, 1, 2);
        sendFrameA("t2b", 1, 0, 3);

        // Early sof after 5 pixels restarts the frame and flags a short frame.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, i == 0, 8'h40 + i, 0);
            checkPixelA($sformatf("t3_px%0d", i), 1, i % 4, i / 4, 8'h40 + i, 0);
        end
        applyStimulus(1, 1, 8'h80, 0);
        checkPixelA("t3_restart", 1, 0, 0, 8'h80, 0);
        checkOutput("t3_short_set", 32'(bus_a.short_frame_err_o), 32'd1);
        checkOutput("t3_count_hold", 32'(bus_a.frame_count_o), 32'd3);
        for (int i = 1; i < 12; i++) begin
            applyStimulus(1, 0, 8'h80 + i, 0);
            checkPixelA($sformatf("t3_rpx%0d", i), 1, i % 4, i / 4, 8'h80 + i, i == 11);
        end
        checkOutput("t3_count", 32'(bus_a.frame_count_o), 32'd4);
        checkOutput("t3_short_sticky", 32'(bus_a.short_frame_err_o), 32'd1);

        // Stray pixels while waiting for sof, then clear priority.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 8'h55, 0);
            checkOutput($sformatf("t4_stray%0d_valid", i), 32'(bus_a.valid_o), 32'd0);
            checkOutput($sformatf("t4_stray%0d_overrun", i), 32'(bus_a.overrun_err_o), 32'd1);
        end
        applyStimulus(1, 0, 8'h55, 1);
        checkOutput("t4_set_wins", 32'(bus_a.overrun_err_o), 32'd1);
        checkOutput("t4_short_cleared", 32'(bus_a.short_frame_err_o), 32'd0);
        checkOutput("t4_hold_data", 32'(bus_a.data_o), 32'h8B);
        applyStimulus(0, 1, 8'h00, 1);
        checkOutput("t4_overrun_cleared", 32'(bus_a.overrun_err_o), 32'd0);
        checkOutput("t4_lone_sof_ignored", 32'(bus_a.valid_o), 32'd0);

        // Reset arriving together with the 7th pixel discards the frame.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, i == 0, 8'h10 + i, 0);
            checkPixelA($sformatf("t6_px%0d", i), 1, i % 4, i / 4, 8'h10 + i, 0);
        end
        rst_a = 1;
        applyStimulus(1, 0, 8'h16, 0);
        rst_a = 0;
        checkPixelA("t6_rst", 0, 0, 0, 0, 0);
        checkOutput("t6_rst_col", 32'(bus_a.col_o), 32'd0);
        checkOutput("t6_rst_row", 32'(bus_a.row_o), 32'd0);
        checkOutput("t6_rst_data", 32'(bus_a.data_o), 32'd0);
        checkOutput("t6_rst_count", 32'(bus_a.frame_count_o), 32'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 0, 8'h17 + i, 0);
            checkOutput($sformatf("t6_drop%0d_valid", i), 32'(bus_a.valid_o), 32'd0);
        end
        checkOutput("t6_overrun", 32'(bus_a.overrun_err_o), 32'd1);
        applyStimulus(0, 0, 0, 1);
        sendFrameA("t6_new", 8'h20, 0, 1);

        // Single-pixel frames: every sof pixel completes a frame; counter wraps.
        applyStimulusB(1, 1, 8'hA5);
        checkOutput("t5_valid", 32'(bus_b.valid_o), 32'd1);
        checkOutput("t5_col", 32'(bus_b.col_o), 32'd0);
        checkOutput("t5_row", 32'(bus_b.row_o), 32'd0);
        checkOutput("t5_data", 32'(bus_b.data_o), 32'hA5);
        checkOutput("t5_done", 32'(bus_b.frame_done_o), 32'd1);
        checkOutput("t5_count1", 32'(bus_b.frame_count_o), 32'd1);
        applyStimulusB(0, 0, 0);
        checkOutput("t5_done_pulse", 32'(bus_b.frame_done_o), 32'd0);
        applyStimulusB(1, 0, 8'h33);
        checkOutput("t5_wait_sof_drop", 32'(bus_b.valid_o), 32'd0);
        checkOutput("t5_wait_sof_overrun", 32'(bus_b.overrun_err_o), 32'd1);
        checkOutput("t5_no_short", 32'(bus_b.short_frame_err_o), 32'd0);
        for (int i = 0; i < 65534; i++) applyStimulusB(1, 1, i);
        checkOutput("t5_count_max", 32'(bus_b.frame_count_o), 32'd65535);
        applyStimulusB(1, 1, 8'h5A);
        checkOutput("t5_count_wrap", 32'(bus_b.frame_count_o), 32'd0);
        checkOutput("t5_wrap_done", 32'(bus_b.frame_done_o), 32'd1);
        checkOutput("t5_wrap_data", 32'(bus_b.data_o), 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
